i2c_slave_block: RTL

- I2C target (slave) endpoint: the other end of the bus that the team's I2C master drives.
- Oversamples raw SCL/SDA on the core clock, detects START/STOP, matches a 7-bit address, ACKs, and receives write bytes into a byte stream.
- Serves read bytes from a byte-stream source.
- Used as the bus-side responder in master bring-up benches and as a reusable target IP. No clock stretching; SCL is input only.

---
 rtl/i2c_slave_block.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_block.sv
// I2C target endpoint: oversampled SCL/SDA, START/STOP detection, 7-bit address match,
// write bytes out as a stream, read bytes served from a stream source. No clock stretching.
module i2c_slave_block #(
  parameter logic [6:0] SLAVE_ADDR = 7'h3C
) (
  input  logic       i2c_core_clock_i,
  input  logic       reset_n_i,
  input  logic       enable_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_full_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       tx_underrun_o,
  output logic       start_o,
  output logic       stop_o,
  output logic       busy_o,
  output logic       addr_match_o,
  output logic       rw_o
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP
  } state_t;

  state_t     state;
  logic       scl_p0, scl_p1, scl_p2;
  logic       sda_p0, sda_p1, sda_p2;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] shift;
  logic [7:0] byte_in;
  logic [7:0] tx_byte;
  logic [2:0] bit_cnt;
  logic       byte_done;
  logic       ack;

  // Stage p0/p1: two-flop synchronizer; p2: previous sample for edge detection.
  // Reset to the idle-bus level so no phantom edge appears after reset.
  always_ff @(posedge i2c_core_clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      scl_p0 <= 1'b1;
      scl_p1 <= 1'b1;
      scl_p2 <= 1'b1;
      sda_p0 <= 1'b1;
      sda_p1 <= 1'b1;
      sda_p2 <= 1'b1;
    end else begin
      scl_p0 <= scl_i;
      scl_p1 <= scl_p0;
      scl_p2 <= scl_p1;
      sda_p0 <= sda_i;
      sda_p1 <= sda_p0;
      sda_p2 <= sda_p1;
    end
  end

  assign scl_rise  = scl_p1 & ~scl_p2;
  assign scl_fall  = ~scl_p1 & scl_p2;
  assign start_det = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
  assign stop_det  = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;
  assign byte_in   = {shift[6:0], sda_p1};
  assign tx_byte   = tx_valid_i ? tx_data_i : 8'hFF;

  // Stage p3: protocol FSM acting on the detected events; all outputs registered.
  always_ff @(posedge i2c_core_clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state         <= IDLE;
      shift         <= 8'h00;
      bit_cnt       <= 3'd0;
      byte_done     <= 1'b0;
      ack           <= 1'b0;
      sda_oe_o      <= 1'b0;
      rx_data_o     <= 8'h00;
      rx_valid_o    <= 1'b0;
      tx_ready_o    <= 1'b0;
      tx_underrun_o <= 1'b0;
      start_o       <= 1'b0;
      stop_o        <= 1'b0;
      busy_o        <= 1'b0;
      addr_match_o  <= 1'b0;
      rw_o          <= 1'b0;
    end else begin
      rx_valid_o    <= 1'b0;
      tx_ready_o    <= 1'b0;
      tx_underrun_o <= 1'b0;
      start_o       <= 1'b0;
      stop_o        <= 1'b0;
      if (!enable_i) begin
        state        <= IDLE;
        sda_oe_o     <= 1'b0;
        busy_o       <= 1'b0;
        addr_match_o <= 1'b0;
        byte_done    <= 1'b0;
      end else if (start_det) begin
        state        <= ADDR;
        bit_cnt      <= 3'd0;
        byte_done    <= 1'b0;
        start_o      <= 1'b1;
        busy_o       <= 1'b1;
        addr_match_o <= 1'b0;
        sda_oe_o     <= 1'b0;
      end else if (stop_det) begin
        state        <= IDLE;
        byte_done    <= 1'b0;
        stop_o       <= 1'b1;
        busy_o       <= 1'b0;
        addr_match_o <= 1'b0;
        sda_oe_o     <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              shift   <= byte_in;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (shift[6:0] == SLAVE_ADDR) begin
                  rw_o         <= sda_p1;
                  addr_match_o <= 1'b1;
                  byte_done    <= 1'b1;
                end else begin
                  state <= WAIT_STOP;
                end
              end
            end else if (scl_fall && byte_done) begin
              state     <= ADDR_ACK;
              sda_oe_o  <= 1'b1;
              byte_done <= 1'b0;
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= 3'd0;
              if (!rw_o) begin
                state    <= RX_DATA;
                sda_oe_o <= 1'b0;
              end else begin
                state         <= TX_DATA;
                shift         <= tx_byte;
                sda_oe_o      <= ~tx_byte[7];
                tx_ready_o    <= tx_valid_i;
                tx_underrun_o <= ~tx_valid_i;
              end
            end
          end
          RX_DATA: begin
            if (scl_rise) begin
              shift   <= byte_in;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                byte_done <= 1'b1;
                ack       <= ~rx_full_i;
                if (!rx_full_i) begin
                  rx_data_o  <= byte_in;
                  rx_valid_o <= 1'b1;
                end
              end
            end else if (scl_fall && byte_done) begin
              state     <= RX_ACK;
              sda_oe_o  <= ack;
              byte_done <= 1'b0;
            end
          end
          RX_ACK: begin
            if (scl_fall) begin
              sda_oe_o <= 1'b0;
              bit_cnt  <= 3'd0;
              state    <= ack ? RX_DATA : WAIT_STOP;
            end
          end
          TX_DATA: begin
            // Bit 7 went out at load time; each fall presents the next lower bit.
            if (scl_fall) begin
              if (bit_cnt == 3'd7) begin
                state    <= TX_ACK;
                sda_oe_o <= 1'b0;
              end else begin
                bit_cnt  <= bit_cnt + 3'd1;
                shift    <= {shift[6:0], 1'b1};
                sda_oe_o <= ~shift[6];
              end
            end
          end
          TX_ACK: begin
            if (scl_rise) begin
              ack <= ~sda_p1;
            end else if (scl_fall) begin
              if (ack) begin
                state         <= TX_DATA;
                bit_cnt       <= 3'd0;
                shift         <= tx_byte;
                sda_oe_o      <= ~tx_byte[7];
                tx_ready_o    <= tx_valid_i;
                tx_underrun_o <= ~tx_valid_i;
              end else begin
                state    <= WAIT_STOP;
                sda_oe_o <= 1'b0;
              end
            end
          end
          WAIT_STOP: sda_oe_o <= 1'b0;
          default: ;
        endcase
      end
    end
  end

endmodule
